shift_sequencer: RTL and testbench

Round-robin controller that shares one combinational New_mXnBits_Shift datapath between REQS requesters. Each request carries a SETS×WIDTH operand and a total shift amount that may exceed the single-pass field. The block splits the amount into passes of at most MAX_STEP = 2^(WIDTH-2)-1, drives the shifter once per cycle, accumulates per-set overflow, and returns the result through a valid/ready response port.

---
 rtl/shift_sequencer_if.sv | 42 ++++
 rtl/shift_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_shift_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: requester, shifter and response signals of the shift
// sequencer. The master modport is the sequencer; the slave modport is the
// surrounding environment (requesters, shifter datapath and consumer).
interface shift_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int SETS  = 2,
   parameter int REQS  = 2,
   parameter int AMT_W = 4
);
   // requester side
   logic [REQS-1:0]            req_valid;
   logic [REQS-1:0]            req_ready;
   logic [REQS*SETS*WIDTH-1:0] req_data;
   logic [REQS*AMT_W-1:0]      req_amt;
   logic [REQS-1:0]            req_dir;
   logic [REQS-1:0]            req_fill;
   // shared shifter datapath
   logic [SETS*WIDTH-1:0]      sh_in_packed;
   logic [SETS*WIDTH-1:0]      sh_shift_packed;
   logic [SETS*WIDTH-1:0]      sh_out_packed;
   logic [SETS*WIDTH-1:0]      sh_overflow_packed;
   // response side
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [SETS*WIDTH-1:0]      rsp_data;
   logic [2:0]                 rsp_id;
   logic [SETS-1:0]            rsp_overflow;

   modport master (
      input  req_valid, req_data, req_amt, req_dir, req_fill,
      input  sh_out_packed, sh_overflow_packed, rsp_ready,
      output req_ready, sh_in_packed, sh_shift_packed,
      output rsp_valid, rsp_data, rsp_id, rsp_overflow
   );

   modport slave (
      output req_valid, req_data, req_amt, req_dir, req_fill,
      output sh_out_packed, sh_overflow_packed, rsp_ready,
      input  req_ready, sh_in_packed, sh_shift_packed,
      input  rsp_valid, rsp_data, rsp_id, rsp_overflow
   );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: round-robin arbiter in front of one shared combinational
// shifter. A granted request is split into passes of at most
// MAX_STEP = 2^(WIDTH-2)-1, one pass per cycle, with per-set overflow
// accumulated across passes and the result returned on a valid/ready port.
// Optional build macro SHIFT_SEQ_CLAMP_EN: clamp accepted amounts above WIDTH
// down to WIDTH, bounding the number of passes.
module shift_sequencer #(
   parameter int WIDTH = 4,
   parameter int SETS  = 2,
   parameter int REQS  = 2,
   parameter int AMT_W = 4
) (
   input logic                clk,
   input logic                rst,
   shift_sequencer_if.master  bus
);

   localparam int MAX_STEP = (2 ** (WIDTH - 2)) - 1;
   localparam int STEP_W   = WIDTH - 2;
   localparam int PTR_W    = (REQS > 1) ? $clog2(REQS) : 1;
   localparam int DW       = SETS * WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nx;
   logic [PTR_W-1:0]   rr_r;
   logic [PTR_W-1:0]   rr_nx_s;
   logic [PTR_W-1:0]   cand_s;
   logic [PTR_W-1:0]   grant_s;
   logic               grant_vld_s;
   logic               accept_s;
   logic [DW-1:0]      data_r;
   logic [AMT_W-1:0]   remaining_r;
   logic               dir_r;
   logic               fill_r;
   logic [PTR_W-1:0]   id_r;
   logic [SETS-1:0]    ovf_r;
   logic [SETS-1:0]    ovf_pass_s;
   logic [DW-1:0]      sel_data_s;
   logic [AMT_W-1:0]   sel_amt_s;
   logic               sel_dir_s;
   logic               sel_fill_s;
   logic [AMT_W-1:0]   amt_acc_s;
   logic [STEP_W-1:0]  step_s;
   logic [WIDTH-1:0]   ctrl_s;

   // Round-robin search: first valid requester at or above the pointer, with wrap.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_s     = '0;
      cand_s      = '0;
      for (int i = 0; i < REQS; i++) begin
         cand_s = PTR_W'((int'(rr_r) + i) % REQS);
         if (!grant_vld_s && bus.req_valid[cand_s]) begin
            grant_vld_s = 1'b1;
            grant_s     = cand_s;
         end else begin
            grant_vld_s = grant_vld_s;
         end
      end
   end

   // Select the granted requester's payload and apply the optional clamp.
   always_comb begin
      sel_data_s = '0;
      sel_amt_s  = '0;
      sel_dir_s  = 1'b0;
      sel_fill_s = 1'b0;
      for (int r = 0; r < REQS; r++) begin
         if (grant_s == PTR_W'(r)) begin
            sel_data_s = bus.req_data[r*DW +: DW];
            sel_amt_s  = bus.req_amt[r*AMT_W +: AMT_W];
            sel_dir_s  = bus.req_dir[r];
            sel_fill_s = bus.req_fill[r];
         end else begin
            sel_data_s = sel_data_s;
         end
      end
`ifdef SHIFT_SEQ_CLAMP_EN
      if (int'(sel_amt_s) > WIDTH) begin
         amt_acc_s = AMT_W'(WIDTH);
      end else begin
         amt_acc_s = sel_amt_s;
      end
`else
      amt_acc_s = sel_amt_s;
`endif
   end

   // Pass size, shifter control word and per-set overflow reduction.
   always_comb begin
      if (int'(remaining_r) > MAX_STEP) begin
         step_s = STEP_W'(MAX_STEP);
      end else begin
         step_s = STEP_W'(remaining_r);
      end
      ctrl_s = {fill_r, step_s, dir_r};
      ovf_pass_s = '0;
      for (int s = 0; s < SETS; s++) begin
         ovf_pass_s[s] = |bus.sh_overflow_packed[s*WIDTH +: WIDTH];
      end
      if (grant_s == PTR_W'(REQS - 1)) begin
         rr_nx_s = '0;
      end else begin
         rr_nx_s = grant_s + PTR_W'(1);
      end
   end

   // Next-state logic of the IDLE/SHIFT/DONE sequencer.
   always_comb begin
      state_nx = state_r;
      accept_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (grant_vld_s) begin
               accept_s = 1'b1;
               if (amt_acc_s != '0) begin
                  state_nx = SHIFT;
               end else begin
                  state_nx = DONE;
               end
            end else begin
               state_nx = IDLE;
            end
         end
         SHIFT: begin
            if (remaining_r == AMT_W'(step_s)) begin
               state_nx = DONE;
            end else begin
               state_nx = SHIFT;
            end
         end
         DONE: begin
            if (bus.rsp_ready) begin
               state_nx = IDLE;
            end else begin
               state_nx = DONE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Drive requester accept, shifter and response outputs from the current state.
   always_comb begin
      bus.req_ready       = '0;
      bus.sh_in_packed    = '0;
      bus.sh_shift_packed = '0;
      bus.rsp_valid       = 1'b0;
      bus.rsp_data        = '0;
      bus.rsp_id          = 3'd0;
      bus.rsp_overflow    = '0;
      case (state_r)
         IDLE: begin
            // Gated by rst so no accept is ever signalled while reset is held.
            for (int r = 0; r < REQS; r++) begin
               bus.req_ready[r] = grant_vld_s && !rst && (grant_s == PTR_W'(r));
            end
         end
         SHIFT: begin
            bus.sh_in_packed    = data_r;
            bus.sh_shift_packed = {SETS{ctrl_s}};
         end
         DONE: begin
            bus.rsp_valid    = 1'b1;
            bus.rsp_data     = data_r;
            bus.rsp_id       = 3'(id_r);
            bus.rsp_overflow = ovf_r;
         end
         default: begin
            bus.rsp_valid = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Request latch, per-pass datapath update, overflow accumulation and rr pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_r        <= '0;
         data_r      <= '0;
         remaining_r <= '0;
         dir_r       <= 1'b0;
         fill_r      <= 1'b0;
         id_r        <= '0;
         ovf_r       <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  data_r      <= sel_data_s;
                  remaining_r <= amt_acc_s;
                  dir_r       <= sel_dir_s;
                  fill_r      <= sel_fill_s;
                  id_r        <= grant_s;
                  rr_r        <= rr_nx_s;
               end
            end
            SHIFT: begin
               data_r      <= bus.sh_out_packed;
               ovf_r       <= ovf_r | ovf_pass_s;
               remaining_r <= remaining_r - AMT_W'(step_s);
            end
            DONE: begin
               if (bus.rsp_ready) begin
                  ovf_r <= '0;
               end
            end
            default: begin
               ovf_r <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed bench for shift_sequencer with WIDTH=4, SETS=2,
// REQS=2, AMT_W=4 (MAX_STEP=3). A small per-set shifter model closes the
// datapath loop; expected values are hand-computed from that model.
module tb_shift_sequencer;

   localparam int WIDTH = 4;
   localparam int SETS  = 2;
   localparam int REQS  = 2;
   localparam int AMT_W = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ovf_drv;
   int         n_checks = 0;
   int         n_pass   = 0;
   int         passes;
   logic [7:0] first_word;
   logic [7:0] last_word;
   int         exp_id [4] = '{1, 0, 1, 0};

   shift_sequencer_if #(.WIDTH(WIDTH), .SETS(SETS), .REQS(REQS), .AMT_W(AMT_W)) bus ();

   shift_sequencer #(.WIDTH(WIDTH), .SETS(SETS), .REQS(REQS), .AMT_W(AMT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // One set of the external shifter: {fill, amount[1:0], dir}; dir=1 shifts right.
   function automatic logic [3:0] shf(input logic [3:0] x, input logic [3:0] c);
      logic [1:0] n;
      logic [3:0] m;
      n = c[2:1];
      if (c[0]) begin
         m = 4'hF >> n;
         return (x >> n) | (c[3] ? ~m : 4'h0);
      end else begin
         m = 4'hF << n;
         return (x << n) | (c[3] ? ~m : 4'h0);
      end
   endfunction

   assign bus.sh_out_packed = {shf(bus.sh_in_packed[7:4], bus.sh_shift_packed[7:4]),
                               shf(bus.sh_in_packed[3:0], bus.sh_shift_packed[3:0])};
   assign bus.sh_overflow_packed = ovf_drv;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [7:0] d, input logic [3:0] a,
                          input logic dir, input logic fill);
      bus.req_data[r*8 +: 8] = d;
      bus.req_amt[r*4 +: 4]  = a;
      bus.req_dir[r]         = dir;
      bus.req_fill[r]        = fill;
   endtask

   task automatic consume();
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      check("rsp_valid_after_consume", 32'(bus.rsp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      ovf_drv       = 8'h00;
      bus.req_valid = 2'b01;
      bus.req_data  = 16'h0000;
      bus.req_amt   = 8'h00;
      bus.req_dir   = 2'b00;
      bus.req_fill  = 2'b00;
      bus.rsp_ready = 1'b0;
      #1;
      // reset state
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_sh_shift", 32'(bus.sh_shift_packed), 32'd0);
      check("rst_sh_in", 32'(bus.sh_in_packed), 32'd0);
      #10;
      bus.req_valid = 2'b00;
      rst = 1'b0;
      tick();

      // multi-pass shift: amt=7 -> 3,3,1
      set_req(0, 8'h81, 4'd7, 1'b0, 1'b0);
      bus.req_valid = 2'b01;
      #1;
      check("mp_ready", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = 2'b00;
      check("mp_sh1", 32'(bus.sh_shift_packed), 32'h66);
      check("mp_in1", 32'(bus.sh_in_packed), 32'h81);
      tick();
      check("mp_sh2", 32'(bus.sh_shift_packed), 32'h66);
      check("mp_in2", 32'(bus.sh_in_packed), 32'h08);
      tick();
      check("mp_sh3", 32'(bus.sh_shift_packed), 32'h22);
      check("mp_in3", 32'(bus.sh_in_packed), 32'h00);
      tick();
      check("mp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("mp_rsp_id", 32'(bus.rsp_id), 32'd0);
      check("mp_rsp_data", 32'(bus.rsp_data), 32'h00);
      check("mp_sh_idle", 32'(bus.sh_shift_packed), 32'h00);
      consume();

      // zero amount from requester 1
      set_req(1, 8'hA5, 4'd0, 1'b0, 1'b0);
      bus.req_valid = 2'b10;
      #1;
      check("z_ready", 32'(bus.req_ready), 32'h2);
      tick();
      bus.req_valid = 2'b00;
      check("z_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("z_sh", 32'(bus.sh_shift_packed), 32'h00);
      check("z_rsp_data", 32'(bus.rsp_data), 32'hA5);
      check("z_rsp_id", 32'(bus.rsp_id), 32'd1);
      consume();

      // right shift by 2 with fill=1: 0x48 -> 0xDE, control 0xDD
      set_req(0, 8'h48, 4'd2, 1'b1, 1'b1);
      bus.req_valid = 2'b01;
      #1;
      check("rf_ready", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = 2'b00;
      check("rf_sh", 32'(bus.sh_shift_packed), 32'hDD);
      check("rf_rsp_valid_early", 32'(bus.rsp_valid), 32'd0);
      tick();
      check("rf_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("rf_rsp_data", 32'(bus.rsp_data), 32'hDE);
      consume();

      // round-robin fairness with both requesters held valid (pointer now 1)
      set_req(0, 8'h11, 4'd0, 1'b0, 1'b0);
      set_req(1, 8'h22, 4'd0, 1'b0, 1'b0);
      bus.req_valid = 2'b11;
      bus.rsp_ready = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("rr_ready", 32'(bus.req_ready), 32'(1 << exp_id[k]));
         tick();
         check("rr_rsp_id", 32'(bus.rsp_id), 32'(exp_id[k]));
         check("rr_rsp_data", 32'(bus.rsp_data), (exp_id[k] == 1) ? 32'h22 : 32'h11);
         check("rr_ready_done", 32'(bus.req_ready), 32'd0);
         if (k == 3) begin
            bus.req_valid = 2'b00;
         end
         tick();
      end
      bus.rsp_ready = 1'b0;

      // reset in the middle of a multi-pass shift (pointer 1, wraps to 0)
      set_req(0, 8'h81, 4'd7, 1'b0, 1'b0);
      bus.req_valid = 2'b01;
      #1;
      check("rs_ready", 32'(bus.req_ready), 32'h1);
      tick();
      tick();
      check("rs_pre_in", 32'(bus.sh_in_packed), 32'h08);
      rst = 1'b1;
      #1;
      check("rs_sh", 32'(bus.sh_shift_packed), 32'd0);
      check("rs_in", 32'(bus.sh_in_packed), 32'd0);
      check("rs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rs_req_ready", 32'(bus.req_ready), 32'd0);
      check("rs_rsp_data", 32'(bus.rsp_data), 32'd0);
      check("rs_rsp_id", 32'(bus.rsp_id), 32'd0);
      check("rs_rsp_ovf", 32'(bus.rsp_overflow), 32'd0);
      #2;
      rst = 1'b0;
      set_req(0, 8'h3C, 4'd0, 1'b0, 1'b0);
      set_req(1, 8'h5C, 4'd0, 1'b0, 1'b0);
      bus.req_valid = 2'b11;
      #1;
      check("rs_rr_zero", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = 2'b00;
      check("rs_rsp_id_after", 32'(bus.rsp_id), 32'd0);
      check("rs_rsp_data_after", 32'(bus.rsp_data), 32'h3C);
      consume();

      // backpressure: hold DONE for 5 cycles (pointer 1, wraps to 0)
      set_req(0, 8'h12, 4'd3, 1'b0, 1'b0);
      bus.req_valid = 2'b01;
      #1;
      check("bp_ready", 32'(bus.req_ready), 32'h1);
      tick();
      set_req(1, 8'h33, 4'd0, 1'b0, 1'b0);
      bus.req_valid = 2'b11;
      check("bp_sh", 32'(bus.sh_shift_packed), 32'h66);
      check("bp_ready_shift", 32'(bus.req_ready), 32'd0);
      tick();
      for (int c = 0; c < 5; c++) begin
         check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check("bp_rsp_data", 32'(bus.rsp_data), 32'h80);
         check("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
         check("bp_req_ready", 32'(bus.req_ready), 32'd0);
         tick();
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      check("bp_idle", 32'(bus.rsp_valid), 32'd0);
      check("bp_next_ready", 32'(bus.req_ready), 32'h2);
      tick();
      bus.req_valid = 2'b00;
      check("bp_next_id", 32'(bus.rsp_id), 32'd1);
      check("bp_next_data", 32'(bus.rsp_data), 32'h33);
      check("bp_one_accept", 32'(bus.req_ready), 32'd0);
      consume();

      // sticky overflow: set 1 reports overflow on the first pass only
      set_req(0, 8'h00, 4'd7, 1'b0, 1'b0);
      bus.req_valid = 2'b01;
      #1;
      check("ov_ready", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = 2'b00;
      ovf_drv = 8'h30;
      tick();
      ovf_drv = 8'h00;
      tick();
      tick();
      check("ov_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("ov_rsp_ovf", 32'(bus.rsp_overflow), 32'h2);
      consume();

      // amt=15, right shift with fill=1: pass count depends on the clamp option
      set_req(1, 8'h00, 4'd15, 1'b1, 1'b1);
      bus.req_valid = 2'b10;
      #1;
      check("cl_ready", 32'(bus.req_ready), 32'h2);
      tick();
      bus.req_valid = 2'b00;
      passes     = 0;
      first_word = 8'h00;
      last_word  = 8'h00;
      for (int c = 0; c < 40 && !bus.rsp_valid; c++) begin
         if (bus.sh_shift_packed != 8'h00) begin
            if (passes == 0) begin
               first_word = bus.sh_shift_packed;
            end
            last_word = bus.sh_shift_packed;
            passes++;
         end
         tick();
      end
      check("cl_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("cl_first", 32'(first_word), 32'hFF);
`ifdef SHIFT_SEQ_CLAMP_EN
      check("cl_passes", 32'(passes), 32'd2);
      check("cl_last", 32'(last_word), 32'hBB);
`else
      check("cl_passes", 32'(passes), 32'd5);
      check("cl_last", 32'(last_word), 32'hFF);
`endif
      check("cl_rsp_data", 32'(bus.rsp_data), 32'hFF);
      check("cl_ovf_cleared", 32'(bus.rsp_overflow), 32'd0);
      check("cl_rsp_id", 32'(bus.rsp_id), 32'd1);
      consume();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
